// File: rtl/kid_hunger_fsm.sv
// kid_hunger_fsm: requester side of the wakeup/food handshake.
// The kid sleeps for a programmed time, raises wakeup and eats food beats
// until full, then digests and goes back to sleep. It also counts meals
// (saturating) and flags overfeeding.
// Optional feature macro: KID_CRY_EN. When it is defined, a starvation
// timeout in HUNGRY raises a sticky cry flag. When it is undefined, the
// timeout logic is not built and cry is tied low.
// All outputs are registered. They are decoded from the next state, so they
// change on the same edge as the state register.
module kid_hunger_fsm #(
   parameter int HUNGER_CYCLES  = 8,
   parameter int EAT_CYCLES     = 4,
   parameter int DIGEST_CYCLES  = 6,
   parameter int TIMEOUT_CYCLES = 16,
   parameter int MEAL_W         = 8
) (
   input  logic              clk,
   input  logic              resetb,
   input  logic              enable,
   input  logic              food,
   output logic              wakeup,
   output logic              full,
   output logic              cry,
   output logic              overfed,
   output logic [MEAL_W-1:0] meals
);

   // One counter width covers every phase; each counter compares and
   // clears, so it never wraps.
   localparam int MAX_HE  = (HUNGER_CYCLES > EAT_CYCLES) ? HUNGER_CYCLES : EAT_CYCLES;
   localparam int MAX_DT  = (DIGEST_CYCLES > TIMEOUT_CYCLES) ? DIGEST_CYCLES : TIMEOUT_CYCLES;
   localparam int MAX_ALL = (MAX_HE > MAX_DT) ? MAX_HE : MAX_DT;
   localparam int CW      = $clog2(MAX_ALL) + 1;

   localparam logic [CW-1:0] SLEEP_LAST = CW'(HUNGER_CYCLES - 1);
   localparam logic [CW-1:0] BITE_LAST  = CW'(EAT_CYCLES - 1);
   localparam logic [CW-1:0] DIG_LAST   = CW'(DIGEST_CYCLES - 1);

   typedef enum logic [1:0] {
      SLEEP  = 2'd0,
      HUNGRY = 2'd1,
      EATING = 2'd2,
      FULL   = 2'd3
   } state_t;

   state_t            state_reg,     state_next;
   logic [CW-1:0]     sleep_cnt_reg, sleep_cnt_next;
   logic [CW-1:0]     bite_cnt_reg,  bite_cnt_next;
   logic [CW-1:0]     dig_cnt_reg,   dig_cnt_next;
   logic [MEAL_W-1:0] meals_reg,     meals_next;
   logic              wakeup_reg,    wakeup_next;
   logic              full_reg,      full_next;
   logic              overfed_reg,   overfed_next;
   logic              cry_reg,       cry_next;

`ifdef KID_CRY_EN
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT_CYCLES - 1);
   logic [CW-1:0]     wait_cnt_reg,  wait_cnt_next;
`endif

   // Next-state, counter and output decode. Everything holds while enable is
   // low, except overfed, which always drops back to 0.
   always_comb begin
      state_next     = state_reg;
      sleep_cnt_next = sleep_cnt_reg;
      bite_cnt_next  = bite_cnt_reg;
      dig_cnt_next   = dig_cnt_reg;
      meals_next     = meals_reg;
      wakeup_next    = wakeup_reg;
      full_next      = full_reg;
      cry_next       = cry_reg;
      overfed_next   = 1'b0;
`ifdef KID_CRY_EN
      wait_cnt_next  = wait_cnt_reg;
`endif
      if (enable) begin
         case (state_reg)
            SLEEP: begin
               overfed_next = food;
               if (sleep_cnt_reg == SLEEP_LAST) begin
                  state_next = HUNGRY;
`ifdef KID_CRY_EN
                  wait_cnt_next = '0;
`endif
               end else begin
                  sleep_cnt_next = sleep_cnt_reg + 1'b1;
               end
            end
            HUNGRY: begin
               if (food) begin
                  cry_next      = 1'b0;
                  bite_cnt_next = CW'(1);
                  if (EAT_CYCLES == 1) begin
                     state_next   = FULL;
                     dig_cnt_next = '0;
                  end else begin
                     state_next = EATING;
                  end
               end else begin
`ifdef KID_CRY_EN
                  if (wait_cnt_reg == WAIT_LAST) begin
                     cry_next = 1'b1;
                  end else begin
                     wait_cnt_next = wait_cnt_reg + 1'b1;
                  end
`endif
               end
            end
            EATING: begin
               // A food=0 beat is a pause, so bite_cnt simply holds.
               if (food) begin
                  if (bite_cnt_reg == BITE_LAST) begin
                     state_next   = FULL;
                     dig_cnt_next = '0;
                  end else begin
                     bite_cnt_next = bite_cnt_reg + 1'b1;
                  end
               end
            end
            FULL: begin
               overfed_next = food;
               if (dig_cnt_reg == DIG_LAST) begin
                  state_next     = SLEEP;
                  sleep_cnt_next = '0;
               end else begin
                  dig_cnt_next = dig_cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next     = SLEEP;
               sleep_cnt_next = '0;
            end
         endcase

         wakeup_next = (state_next == HUNGRY) || (state_next == EATING);
         full_next   = (state_next == FULL);
         if ((state_next == FULL) && (state_reg != FULL) && (meals_reg != '1)) begin
            meals_next = meals_reg + 1'b1;
         end
      end
   end

   // State, counter and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         state_reg     <= SLEEP;
         sleep_cnt_reg <= '0;
         bite_cnt_reg  <= '0;
         dig_cnt_reg   <= '0;
         meals_reg     <= '0;
         wakeup_reg    <= 1'b0;
         full_reg      <= 1'b0;
         cry_reg       <= 1'b0;
         overfed_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sleep_cnt_reg <= sleep_cnt_next;
         bite_cnt_reg  <= bite_cnt_next;
         dig_cnt_reg   <= dig_cnt_next;
         meals_reg     <= meals_next;
         wakeup_reg    <= wakeup_next;
         full_reg      <= full_next;
         cry_reg       <= cry_next;
         overfed_reg   <= overfed_next;
      end
   end

`ifdef KID_CRY_EN
   // The starvation timer exists only when the cry feature is built.
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wait_cnt_reg <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
      end
   end
   assign cry = cry_reg;
`else
   assign cry = 1'b0;
`endif

   assign wakeup  = wakeup_reg;
   assign full    = full_reg;
   assign overfed = overfed_reg;
   assign meals   = meals_reg;

endmodule

// File: tb/tb_kid_hunger_fsm.sv
// tb_kid_hunger_fsm: directed checks for kid_hunger_fsm. The first part is a
// per-cycle vector table. Hand-written sequences then cover the multi-cycle
// corner cases: paused feeding, starvation, meal saturation, reset while
// eating, and a long enable gap. A second instance with MEAL_W=2 shares the
// same stimulus so that meal-counter saturation can be observed.
module tb_kid_hunger_fsm;

   logic       clk    = 1'b0;
   logic       resetb = 1'b0;
   logic       enable = 1'b0;
   logic       food   = 1'b0;
   logic       wakeup, full, cry, overfed;
   logic [7:0] meals;
   logic       wakeup2, full2, cry2, overfed2;
   logic [1:0] meals2;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic en;
      logic fd;
      logic wk;
      logic fl;
      logic ov;
      int   ml;
   } vec_t;

   vec_t tbl[$];

   always #5 clk = ~clk;

   kid_hunger_fsm dut (
      .clk(clk), .resetb(resetb), .enable(enable), .food(food),
      .wakeup(wakeup), .full(full), .cry(cry), .overfed(overfed), .meals(meals)
   );

   kid_hunger_fsm #(.MEAL_W(2)) dut2 (
      .clk(clk), .resetb(resetb), .enable(enable), .food(food),
      .wakeup(wakeup2), .full(full2), .cry(cry2), .overfed(overfed2), .meals(meals2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drive the inputs, then sample the outputs 1 time unit after the next rising edge.
   task automatic step(input logic en, input logic fd);
      enable = en;
      food   = fd;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic en, input logic fd, input logic wk,
                      input logic fl, input logic ov, input int ml);
      vec_t v;
      v.en = en; v.fd = fd; v.wk = wk; v.fl = fl; v.ov = ov; v.ml = ml;
      tbl.push_back(v);
   endtask

   // Step with food=0 until wakeup rises. Returns the number of edges taken.
   task automatic wait_wakeup(input int max_edges, output int cnt);
      cnt = 0;
      while (!wakeup && cnt < max_edges) begin
         step(1'b1, 1'b0);
         cnt++;
      end
      if (!wakeup) begin
         n_checks++;
         n_fail++;
         $display("FAIL wait_wakeup: timed out after %0d edges", cnt);
      end
   endtask

   task automatic do_meal(input string name);
      int c;
      wait_wakeup(40, c);
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b1);
      chk({name, "_full"}, full, 1);
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b0);
      chk({name, "_digest_done"}, full, 0);
      $display("meal %s done: meals=%0d meals2=%0d", name, meals, meals2);
   endtask

   initial begin
      int c;
      logic any_cry;

      // Vector table, one row per edge after reset release:
      //  en fd | wakeup full overfed meals
      for (int i = 1; i <= 7; i++) add(1, 0, 0, 0, 0, 0);   // sleeping
      add(1, 0, 1, 0, 0, 0);                                 // edge 8: hungry
      for (int i = 9; i <= 11; i++) add(1, 1, 1, 0, 0, 0);  // eating
      add(1, 1, 0, 1, 0, 1);                                 // edge 12: full, meal 1
      for (int i = 13; i <= 15; i++) add(1, 1, 0, 1, 1, 1); // overfeed in FULL
      add(1, 0, 0, 1, 0, 1);
      add(1, 0, 0, 1, 0, 1);
      add(1, 0, 0, 0, 0, 1);                                 // edge 18: back to SLEEP
      add(1, 1, 0, 0, 1, 1);                                 // overfeed in SLEEP
      add(0, 0, 0, 0, 0, 1);                                 // overfed drops while disabled
      add(0, 1, 0, 0, 0, 1);                                 // no pulse while disabled
      add(0, 0, 0, 0, 0, 1);
      for (int i = 23; i <= 28; i++) add(1, 0, 0, 0, 0, 1);
      add(1, 0, 1, 0, 0, 1);                                 // edge 29: 3 edges late

      // Reset state
      #1;
      chk("reset_wakeup", wakeup, 0);
      chk("reset_full", full, 0);
      chk("reset_cry", cry, 0);
      chk("reset_overfed", overfed, 0);
      chk("reset_meals", meals, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;

      foreach (tbl[i]) begin
         step(tbl[i].en, tbl[i].fd);
         $display("vec %0d: en=%0b food=%0b -> wakeup=%0b full=%0b overfed=%0b meals=%0d",
                  i + 1, tbl[i].en, tbl[i].fd, wakeup, full, overfed, meals);
         chk($sformatf("vec%0d_wakeup", i + 1), wakeup, tbl[i].wk);
         chk($sformatf("vec%0d_full", i + 1), full, tbl[i].fl);
         chk($sformatf("vec%0d_overfed", i + 1), overfed, tbl[i].ov);
         chk($sformatf("vec%0d_meals", i + 1), meals, tbl[i].ml);
         chk($sformatf("vec%0d_cry", i + 1), cry, 0);
      end

      // Paused feeding: food 1,1,0,0,1,1
      begin
         logic pat[6];
         pat = '{1, 1, 0, 0, 1, 1};
         for (int i = 0; i < 6; i++) begin
            step(1'b1, pat[i]);
            chk($sformatf("pause%0d_wakeup", i + 1), wakeup, (i < 5) ? 1 : 0);
            chk($sformatf("pause%0d_full", i + 1), full, (i == 5) ? 1 : 0);
         end
         chk("pause_meals", meals, 2);
         $display("paused feeding done: meals=%0d", meals);
      end
      for (int i = 1; i <= 6; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("digest%0d_full", i), full, (i < 6) ? 1 : 0);
      end
      wait_wakeup(40, c);
      chk("sleep_len", c, 8);

      // Starvation
`ifdef KID_CRY_EN
      for (int i = 1; i <= 16; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("starve%0d_cry", i), cry, (i == 16) ? 1 : 0);
      end
      step(1'b1, 1'b0);
      chk("cry_sticky", cry, 1);
      chk("cry_still_hungry", wakeup, 1);
`else
      any_cry = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         step(1'b1, 1'b0);
         any_cry = any_cry | cry;
      end
      chk("no_cry_100", any_cry, 0);
      chk("no_cry_still_hungry", wakeup, 1);
`endif
      step(1'b1, 1'b1);
      chk("fed_cry_clear", cry, 0);
      chk("fed_eating_wakeup", wakeup, 1);
      chk("fed_eating_full", full, 0);
      $display("starvation sequence done: cry=%0b wakeup=%0b", cry, wakeup);
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b1);
      chk("meal3_full", full, 1);
      chk("meal3_meals", meals, 3);
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b0);

      // Saturation of the 2-bit meal counter
      do_meal("m4");
      do_meal("m5");
      chk("meals_8bit", meals, 5);
      chk("meals_2bit_sat", meals2, 3);

      // Reset while EATING with bite_cnt=2
      wait_wakeup(40, c);
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      #2;
      resetb = 1'b0;
      #1;
      chk("rst_eat_wakeup", wakeup, 0);
      chk("rst_eat_full", full, 0);
      chk("rst_eat_cry", cry, 0);
      chk("rst_eat_meals", meals, 0);
      chk("rst_eat_meals2", meals2, 0);
      $display("async reset mid-eating: wakeup=%0b meals=%0d", wakeup, meals);
      @(posedge clk);
      @(negedge clk);
      resetb = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0);
         chk($sformatf("rel%0d_wakeup", i), wakeup, (i == 8) ? 1 : 0);
      end

      // 10-cycle enable gap in SLEEP delays wakeup by exactly 10 edges
      for (int i = 1; i <= 4; i++) step(1'b1, 1'b1);
      chk("gap_meal_meals", meals, 1);
      for (int i = 1; i <= 6; i++) step(1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) step(1'b1, 1'b0);
      for (int i = 1; i <= 10; i++) begin
         step(1'b0, 1'b0);
         chk($sformatf("gap%0d_wakeup", i), wakeup, 0);
      end
      wait_wakeup(40, c);
      chk("gap_remaining_len", c, 5);
      $display("enable gap done: remaining sleep edges=%0d", c);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "watchdog");
   end

endmodule
